wire_binary_tree_1_n_mcast_pipe: RTL and testbench
==================================================

# wire_binary_tree_1_n_mcast_pipe

Pipelined 1-to-N binary-tree distributor with per-beat destination masks (unicast, multicast or broadcast) and per-output valid/ready backpressure. It succeeds the fixed 1-to-8 broadcast tree. Output count and data width are parametrised, and branches that lead to no destination are pruned at every level. It sits between a single producer, such as a weight/activation fetch unit, and N consumer PEs or lanes in the NoC distribution layer.

## Interface
- DATA_WIDTH, 32, payload bits per beat; any value ≥ 1.
- NUM_OUTPUT_DATA, 8, number of output ports; power of 2, ≥ 2. NUM_LEVEL = $clog2(NUM_OUTPUT_DATA).
- ZERO_INVALID, 1, when 1 every data slot whose valid is 0 is written as all-zero; when 0 data propagates unmasked.
- DROP_CNT_WIDTH, 16, width of the saturating drop counter.
- Clocking/reset: one clock; reset is asynchronous and active-low.
- CLK  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  global enable; when 0 all state holds (no clear, unlike the previous generation).
- i_flush  in  1  synchronous flush; clears all valid state.
- i_valid  in  1  input beat valid.
- i_data_bus  in  DATA_WIDTH  input payload.
- i_dest_mask  in  NUM_OUTPUT_DATA  destination bitmap; bit n targets output n.
- o_in_ready  out  1  input accepted on posedge when i_valid && o_in_ready.
- o_valid  out  NUM_OUTPUT_DATA  per-output valid (registered).
- o_data_bus  out  NUM_OUTPUT_DATA*DATA_WIDTH  output n at [n*DATA_WIDTH +: DATA_WIDTH] (registered).
- i_out_ready  in  NUM_OUTPUT_DATA  per-output consumer ready.
- o_busy  out  1  any valid bit set in any tree level or the output stage.
- o_drop_cnt  out  DROP_CNT_WIDTH  count of accepted beats with an all-zero mask; saturates at all-ones.

## Operation
- Tree level k (k = 0..NUM_LEVEL-1) holds 2^k node registers. Each node has data, valid and a subtree mask of NUM_OUTPUT_DATA>>k bits.
- Node j at level k covers outputs j*(N>>k) .. (j+1)*(N>>k)-1.
- Level 0 load:
  - valid = accepted && |i_dest_mask
  - mask = i_dest_mask
  - data = i_data_bus
- Child c∈{0,1} of a parent node:
  - mask = the lower (c=0) or upper (c=1) half of the parent mask
  - valid = parent.valid && |child mask
  - data = parent data
- Output stage: last-level node j drives outputs 2j and 2j+1. o_valid[n] = node.valid && mask bit for n.
- advance = i_en && !i_flush && ((o_valid & ~i_out_ready) == 0). o_in_ready = advance.
- When advance is 1: every level and the output stage load from their predecessor. Level 0 loads invalid if no input is accepted.
- When advance is 0 and i_en is 1: tree levels hold. o_valid &= ~i_out_ready, so outputs that handshook drop while blocked outputs keep valid and data.
- When i_en is 0: everything holds, including o_valid, even if i_out_ready is set. A consumer must not count a transfer while i_en is 0.
- Flush:
  - i_flush = 1 clears every valid bit (tree levels and o_valid) on the next edge, regardless of i_en and ready.
  - Data and mask registers are left as-is, except when ZERO_INVALID = 1, where data is zeroed.
  - No input is accepted in a flush cycle.
- Drop counter: increments when i_valid && o_in_ready && i_dest_mask == 0. It holds at its maximum value and is not cleared by flush.
- o_busy = OR of all valid bits; combinational from registers.

## Timing
- Reset (rst_n = 0): all valid bits 0, all data and mask registers 0, o_drop_cnt 0, o_valid 0, o_data_bus 0, o_busy 0. o_in_ready equals i_en once rst_n is 1.
- Latency: a beat accepted at edge t appears on o_valid/o_data_bus after edge t+NUM_LEVEL, i.e. NUM_LEVEL+1 register stages. With N = 8 this is 4 stages: levels 0–2 plus the output stage.
- Throughput: one beat per cycle when all targeted outputs are ready every cycle.
- o_in_ready is combinational from i_en, i_flush, o_valid registers and i_out_ready. There is no path from i_valid or i_dest_mask.
- A blocked output stalls the whole tree (head-of-line). Beats are never reordered or duplicated.
- Reset asserted mid-stream: all in-flight beats are lost immediately and asynchronously.

## Test plan
- Broadcast, N=8, W=32: send 0xA5A5_0001 with mask 0xFF and all ready. After 4 stages o_valid = 0xFF and all 8 lanes read 0xA5A5_0001 for one cycle; o_busy falls afterwards.
- Unicast/multicast: send beats with masks 0x01, 0x80, 0x5A back-to-back. Outputs show o_valid 0x01, 0x80, 0x5A on consecutive cycles. With ZERO_INVALID=1, untargeted lanes read 0.
- Partial backpressure: mask 0xFF, i_out_ready = 0x0F for 2 cycles, then 0xF0. o_valid goes 0xFF → 0xF0, holds, then 0x00. o_in_ready stays 0 until the final drain cycle, and no beat is duplicated.
- Enable hold: stream 6 beats and drop i_en for 3 cycles mid-stream. All registers freeze, o_in_ready = 0, and the output sequence resumes with no loss or repeat.
- Drop/flush: send 3 beats with mask 0x00, so o_drop_cnt = 3 and no o_valid appears. Fill the pipe, then assert i_flush for 1 cycle: o_valid = 0 and o_busy = 0 next cycle, and o_drop_cnt stays 3. With DROP_CNT_WIDTH=2, 5 drops read 3.
- Async reset mid-stream: assert rst_n = 0 between edges with the pipe full. Outputs go to 0 without waiting for CLK, and the first beat after release arrives with full latency.

Source files
------------

// File: rtl/wire_binary_tree_1_n_mcast_pipe_if.sv
// Producer/consumer bundle of the 1-to-N multicast tree: input beat with destination mask,
// per-output valid/data/ready, plus enable, flush, busy and drop-count sideband.
interface wire_binary_tree_1_n_mcast_pipe_if #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTPUT_DATA = 8,
    parameter int DROP_CNT_WIDTH  = 16
);
    logic                                    i_en;
    logic                                    i_flush;
    logic                                    i_valid;
    logic [DATA_WIDTH-1:0]                   i_data_bus;
    logic [NUM_OUTPUT_DATA-1:0]              i_dest_mask;
    logic                                    o_in_ready;
    logic [NUM_OUTPUT_DATA-1:0]              o_valid;
    logic [NUM_OUTPUT_DATA*DATA_WIDTH-1:0]   o_data_bus;
    logic [NUM_OUTPUT_DATA-1:0]              i_out_ready;
    logic                                    o_busy;
    logic [DROP_CNT_WIDTH-1:0]               o_drop_cnt;

    modport master (
        output i_en, i_flush, i_valid, i_data_bus, i_dest_mask, i_out_ready,
        input  o_in_ready, o_valid, o_data_bus, o_busy, o_drop_cnt
    );

    modport slave (
        input  i_en, i_flush, i_valid, i_data_bus, i_dest_mask, i_out_ready,
        output o_in_ready, o_valid, o_data_bus, o_busy, o_drop_cnt
    );
endinterface

// File: rtl/wire_binary_tree_1_n_mcast_pipe.sv
// Pipelined 1-to-N binary-tree multicast distributor, NUM_LEVEL+1 register stages of latency;
// any targeted output not ready stalls the whole tree, handshaken outputs drop while others hold.
module wire_binary_tree_1_n_mcast_pipe #(
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_OUTPUT_DATA = 8,
    parameter bit ZERO_INVALID    = 1'b1,
    parameter int DROP_CNT_WIDTH  = 16
) (
    input logic CLK,
    input logic rst_n,
    wire_binary_tree_1_n_mcast_pipe_if.slave bus
);
    localparam int N         = NUM_OUTPUT_DATA;
    localparam int NUM_LEVEL = $clog2(N);
    localparam int NN        = N - 1;      // tree nodes, heap-ordered: children of p are 2p+1, 2p+2
    localparam int LEAF0     = N / 2 - 1;  // heap index of the first last-level node

    logic [DATA_WIDTH-1:0]     nd_dat [NN];
    logic [N-1:0]              nd_msk [NN];
    logic [NN-1:0]             nd_vld;
    logic [DATA_WIDTH-1:0]     nx_dat [NN];
    logic [N-1:0]              nx_msk [NN];
    logic [NN-1:0]             nx_vld;
    logic [N-1:0]              out_vld;
    logic [N-1:0]              nx_ovld;
    logic [DATA_WIDTH-1:0]     out_dat [N];
    logic [DATA_WIDTH-1:0]     nx_odat [N];
    logic [DROP_CNT_WIDTH-1:0] drop_cnt;
    logic                      adv;
    logic                      acc;

    // Masks are kept in absolute output positions; bits outside a node's span are
    // constant zero, so each node effectively holds only its N>>k subtree bits.
    function automatic logic [N-1:0] node_range(input int idx);
        logic [N-1:0] r;
        int           lvl;
        int           pos;
        int           span;
        lvl = 0;
        for (int l = 0; l < NUM_LEVEL; l++) begin
            if (idx >= (1 << l) - 1) lvl = l;
        end
        pos  = idx - ((1 << lvl) - 1);
        span = N >> lvl;
        r    = '0;
        for (int b = 0; b < N; b++) begin
            if (b >= pos * span && b < (pos + 1) * span) r[b] = 1'b1;
        end
        return r;
    endfunction

    assign adv            = bus.i_en && !bus.i_flush && ((out_vld & ~bus.i_out_ready) == '0);
    assign acc            = bus.i_valid && adv;
    assign bus.o_in_ready = adv;
    assign bus.o_valid    = out_vld;
    assign bus.o_busy     = (|nd_vld) || (|out_vld);
    assign bus.o_drop_cnt = drop_cnt;

    for (genvar n = 0; n < N; n++) begin : g_out
        assign bus.o_data_bus[n*DATA_WIDTH +: DATA_WIDTH] = out_dat[n];
    end

    always_comb begin
        nx_vld  = '0;
        nx_ovld = '0;
        for (int i = 0; i < NN; i++) begin
            logic [N-1:0] m;
            if (i == 0) begin
                m         = bus.i_dest_mask;
                nx_vld[i] = acc && (|m);
                nx_dat[i] = bus.i_data_bus;
            end else begin
                m         = nd_msk[(i-1)/2] & node_range(i);
                nx_vld[i] = nd_vld[(i-1)/2] && (|m);
                nx_dat[i] = nd_dat[(i-1)/2];
            end
            nx_msk[i] = m;
            if (ZERO_INVALID && !nx_vld[i]) nx_dat[i] = '0;
        end
        for (int n = 0; n < N; n++) begin
            nx_ovld[n] = nd_vld[LEAF0 + n/2] && nd_msk[LEAF0 + n/2][n];
            nx_odat[n] = (ZERO_INVALID && !nx_ovld[n]) ? '0 : nd_dat[LEAF0 + n/2];
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            nd_vld  <= '0;
            out_vld <= '0;
            for (int i = 0; i < NN; i++) begin
                nd_dat[i] <= '0;
                nd_msk[i] <= '0;
            end
            for (int n = 0; n < N; n++) out_dat[n] <= '0;
        end else if (bus.i_flush) begin
            nd_vld  <= '0;
            out_vld <= '0;
            if (ZERO_INVALID) begin
                for (int i = 0; i < NN; i++) nd_dat[i] <= '0;
                for (int n = 0; n < N; n++) out_dat[n] <= '0;
            end
        end else if (bus.i_en) begin
            if (adv) begin
                nd_vld  <= nx_vld;
                out_vld <= nx_ovld;
                for (int i = 0; i < NN; i++) begin
                    nd_dat[i] <= nx_dat[i];
                    nd_msk[i] <= nx_msk[i];
                end
                for (int n = 0; n < N; n++) out_dat[n] <= nx_odat[n];
            end else begin
                // Stalled: retire only the outputs that handshook this cycle.
                out_vld <= out_vld & ~bus.i_out_ready;
                if (ZERO_INVALID) begin
                    for (int n = 0; n < N; n++) begin
                        if (out_vld[n] && bus.i_out_ready[n]) out_dat[n] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (acc && bus.i_dest_mask == '0 && drop_cnt != '1) begin
            drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_wire_binary_tree_1_n_mcast_pipe.sv
// Directed + randomized bench for the multicast tree against a whole-beat pipeline model.
module tb_wire_binary_tree_1_n_mcast_pipe;
    localparam int W    = 32;
    localparam int N    = 8;
    localparam int L    = 3;
    localparam int DCW  = 2;
    localparam int DMAX = (1 << DCW) - 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    wire_binary_tree_1_n_mcast_pipe_if #(.DATA_WIDTH(W), .NUM_OUTPUT_DATA(N), .DROP_CNT_WIDTH(DCW)) bus ();

    wire_binary_tree_1_n_mcast_pipe #(
        .DATA_WIDTH(W), .NUM_OUTPUT_DATA(N), .ZERO_INVALID(1'b1), .DROP_CNT_WIDTH(DCW)
    ) dut (
        .CLK  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Reference: a beat travels whole (mask + data) through L slots, then lands on the outputs.
    typedef struct packed {
        logic         v;
        logic [N-1:0] m;
        logic [W-1:0] d;
    } beat_t;

    beat_t        pipe [L];
    logic [N-1:0] m_ovld;
    logic [W-1:0] m_odat [N];
    int           m_drop;
    bit           m_wrote;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_adv();
        return bus.i_en && !bus.i_flush && ((m_ovld & ~bus.i_out_ready) == '0);
    endfunction

    function automatic bit exp_busy();
        bit b;
        b = |m_ovld;
        for (int i = 0; i < L; i++) b = b | pipe[i].v;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < L; i++) pipe[i] = '0;
        for (int n = 0; n < N; n++) m_odat[n] = '0;
        m_ovld  = '0;
        m_drop  = 0;
        m_wrote = 0;
    endtask

    task automatic model_edge();
        bit adv;
        adv     = exp_adv();
        m_wrote = 0;
        if (bus.i_flush) begin
            for (int i = 0; i < L; i++) pipe[i].v = 1'b0;
            m_ovld  = '0;
            m_wrote = 1;
        end else if (bus.i_en) begin
            if (adv) begin
                m_ovld = pipe[L-1].v ? pipe[L-1].m : '0;
                for (int n = 0; n < N; n++) m_odat[n] = pipe[L-1].d;
                for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
                pipe[0].v = bus.i_valid && (bus.i_dest_mask != '0);
                pipe[0].m = bus.i_dest_mask;
                pipe[0].d = bus.i_data_bus;
                m_wrote   = 1;
                if (bus.i_valid && bus.i_dest_mask == '0 && m_drop < DMAX) m_drop++;
            end else begin
                m_ovld = m_ovld & ~bus.i_out_ready;
            end
        end
    endtask

    task automatic check_out(input string ph);
        logic [W-1:0] lane;
        chk({ph, ".o_valid"}, bus.o_valid, m_ovld);
        chk({ph, ".drop_cnt"}, bus.o_drop_cnt, m_drop);
        for (int n = 0; n < N; n++) begin
            lane = bus.o_data_bus[n*W +: W];
            if (m_ovld[n]) chk($sformatf("%s.lane%0d", ph, n), lane, m_odat[n]);
            else if (m_wrote) chk($sformatf("%s.zero%0d", ph, n), lane, '0);
        end
    endtask

    task automatic step(input string ph);
        #2;
        chk({ph, ".in_ready"}, bus.o_in_ready, exp_adv());
        chk({ph, ".busy"}, bus.o_busy, exp_busy());
        model_edge();
        @(posedge clk);
        #1;
        check_out(ph);
    endtask

    task automatic drive(input bit v, input logic [N-1:0] m, input logic [W-1:0] d);
        bus.i_valid     = v;
        bus.i_dest_mask = m;
        bus.i_data_bus  = d;
    endtask

    function automatic logic [N-1:0] rnd_nz_mask();
        logic [N-1:0] m;
        m = N'($urandom_range(1, (1 << N) - 1));
        return m;
    endfunction

    initial begin
        logic [N-1:0] uni [3];
        bus.i_en        = 1'b0;
        bus.i_flush     = 1'b0;
        bus.i_out_ready = '1;
        drive(0, '0, '0);
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.o_valid", bus.o_valid, '0);
        chk("rst.busy", bus.o_busy, 0);
        chk("rst.drop", bus.o_drop_cnt, 0);
        chk("rst.data_zero", (bus.o_data_bus == '0), 1);
        rst_n  = 1'b1;
        #1;
        chk("rst.in_ready_en0", bus.o_in_ready, 0);
        bus.i_en = 1'b1;
        #1;
        chk("rst.in_ready_en1", bus.o_in_ready, 1);

        // Broadcast
        drive(1, 8'hFF, 32'hA5A5_0001);
        step("bcast");
        drive(0, '0, '0);
        repeat (3) step("bcast");
        chk("bcast.vld_at4", bus.o_valid, 8'hFF);
        chk("bcast.lane7", bus.o_data_bus[7*W +: W], 32'hA5A5_0001);
        step("bcast_tail");
        chk("bcast.vld_after", bus.o_valid, 8'h00);
        chk("bcast.busy_after", bus.o_busy, 0);

        // Unicast / multicast back-to-back
        uni[0] = 8'h01; uni[1] = 8'h80; uni[2] = 8'h5A;
        for (int b = 0; b < 3; b++) begin
            drive(1, uni[b], $urandom);
            step("mcast");
        end
        drive(0, '0, '0);
        step("mcast");
        chk("mcast.vld01", bus.o_valid, 8'h01);
        step("mcast");
        chk("mcast.vld80", bus.o_valid, 8'h80);
        step("mcast");
        chk("mcast.vld5A", bus.o_valid, 8'h5A);
        repeat (2) step("mcast");

        // Partial backpressure with beats queued behind the blocked one
        bus.i_out_ready = 8'h0F;
        drive(1, 8'hFF, $urandom);
        step("bp");
        for (int b = 0; b < 2; b++) begin
            drive(1, rnd_nz_mask(), $urandom);
            step("bp");
        end
        drive(0, '0, '0);
        step("bp");
        chk("bp.vld_full", bus.o_valid, 8'hFF);
        step("bp");
        chk("bp.vld_hi", bus.o_valid, 8'hF0);
        step("bp");
        chk("bp.vld_hold", bus.o_valid, 8'hF0);
        bus.i_out_ready = 8'hF0;
        step("bp");
        bus.i_out_ready = '1;
        repeat (L + 2) step("bp_drain");

        // Enable hold mid-stream
        for (int b = 0; b < 6; b++) begin
            drive(1, rnd_nz_mask(), $urandom);
            if (b == 3) begin
                bus.i_en = 1'b0;
                repeat (3) begin
                    bus.i_out_ready = N'($urandom);
                    step("en_hold");
                end
                bus.i_en        = 1'b1;
                bus.i_out_ready = '1;
            end
            step("en_stream");
        end
        drive(0, '0, '0);
        repeat (L + 2) step("en_drain");

        // Drops, saturation and flush
        for (int b = 0; b < 3; b++) begin
            drive(1, '0, $urandom);
            step("drop");
        end
        chk("drop.cnt3", bus.o_drop_cnt, 3);
        for (int b = 0; b < 2; b++) begin
            drive(1, '0, $urandom);
            step("drop_sat");
        end
        drive(0, '0, '0);
        repeat (L + 1) step("drop_idle");
        chk("drop.sat", bus.o_drop_cnt, DMAX);
        for (int b = 0; b < 4; b++) begin
            drive(1, 8'hFF, $urandom);
            step("fill");
        end
        bus.i_flush = 1'b1;
        step("flush");
        bus.i_flush = 1'b0;
        drive(0, '0, '0);
        chk("flush.vld", bus.o_valid, 8'h00);
        chk("flush.busy", bus.o_busy, 0);
        chk("flush.drop", bus.o_drop_cnt, DMAX);
        step("flush_after");

        // Randomized soak
        for (int c = 0; c < 400; c++) begin
            int r;
            r = $urandom_range(0, 3);
            drive($urandom_range(0, 9) < 7,
                  (r == 0) ? N'(0) : (r == 1) ? N'(8'hFF) : N'($urandom), $urandom);
            bus.i_out_ready = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            bus.i_en        = ($urandom_range(0, 9) != 0);
            bus.i_flush     = ($urandom_range(0, 29) == 0);
            step("soak");
        end
        bus.i_en        = 1'b1;
        bus.i_flush     = 1'b0;
        bus.i_out_ready = '1;

        // Asynchronous reset with the pipe full
        for (int b = 0; b < 4; b++) begin
            drive(1, rnd_nz_mask(), $urandom);
            step("pre_arst");
        end
        drive(0, '0, '0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.o_valid", bus.o_valid, '0);
        chk("arst.busy", bus.o_busy, 0);
        chk("arst.data_zero", (bus.o_data_bus == '0), 1);
        chk("arst.drop", bus.o_drop_cnt, 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 8'hFF, 32'h1234_5678);
        step("post_arst");
        drive(0, '0, '0);
        repeat (2) step("post_arst");
        chk("arst.not_early", bus.o_valid, 8'h00);
        step("post_arst");
        chk("arst.latency", bus.o_valid, 8'hFF);
        step("post_arst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before 200000");
        $fatal(1, "timeout");
    end
endmodule
